lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store sequencer in front of the data memory (2-read/1-write, byte-masked, word-addressed
//  internally). Accepts byte/half/word loads and stores at any byte address. Generates the byte
//  write mask and store-data shift, and sign- or zero-extends load data. Splits accesses that
//  cross a word boundary into two sequential word accesses. Owns memory read port 0 and the
//  write port; read port 1 stays with instruction fetch.
// PARAMETERS
//  XLEN   32  data width (must be 32; 4 byte lanes)
//  DEPTH  32  memory depth in words; MEM_AW = $clog2(DEPTH)+2 is the byte-address width
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept; handshake = req_valid & req_ready
//  req_we     in   1       1 = store, 0 = load
//  req_size   in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_uns    in   1       load zero-extend (1) / sign-extend (0); ignored for stores
//  req_addr   in   MEM_AW  byte address, any alignment
//  req_wdata  in   XLEN    store data, right-justified
//  rsp_valid  out  1       one-cycle pulse; load data / completion valid
//  rsp_rdata  out  XLEN    extended load data; 0 for stores and errors
//  rsp_err    out  1       qualifies rsp_valid; set for size 11
//  mem_raddr  out  MEM_AW  to memory rd_addr0; word-aligned byte address (bits[1:0]=00)
//  mem_rdata  in   XLEN    from memory rd_dout0; combinational read of mem_raddr
//  mem_waddr  out  MEM_AW  to memory wr_addr0; word-aligned byte address
//  mem_wdata  out  XLEN    lane-aligned store data
//  mem_we     out  1       write enable, committed at posedge
//  mem_wmask  out  4       byte-lane mask
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured low word=0. mem_we=0 while rst=1.
//  Let off=addr[1:0] and nb=1/2/4 for size 00/01/10. The access is split iff off+nb>4.
//  wide_mask[6:0] = ({1,3,F}[size] << off). wide_data[55:0] = wdata << 8*off.
//  IDLE: req_ready=1. mem_raddr/mem_waddr = {addr[MEM_AW-1:2],2'b00}, combinational from the request.
//   accept, size=11: no memory write. Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
//   accept, not split: store drives mem_we=1, mem_wmask=wide_mask[3:0], mem_wdata=wide_data[31:0].
//     Load captures mem_rdata. Next cycle: rsp_valid=1 (latency 1).
//   accept, split: first word as above, with mask wide_mask[3:0]. Load captures the low word.
//     Latch addr+4 (word index mod DEPTH, so the top word wraps to word 0), size, uns,
//     wide_mask[6:4] and wide_data[55:32]. Go to SPLIT.
//  SPLIT: req_ready=0. Access the latched next word. Store uses mask {0,wide_mask[6:4]}.
//   Load combines {mem_rdata, low} >> 8*off. Next cycle: rsp_valid=1 (latency 2). Return to IDLE.
//  Load extend: take the low 8/16/32 bits; sign-extend unless uns. rsp_rdata is registered.
//  rsp_valid has no backpressure. A new request may be accepted in the same cycle rsp_valid=1
//   (back-to-back, 1 req/cycle aligned, 1 req/2 cycles split).
//  mem_we=0 in every cycle without an accepted or in-progress store.
//  rst asserted in SPLIT: abort; the second half is not written (the first half stays committed),
//   and no response is issued.
//  Misaligned access is legal, never trapped. rsp_err is set only for size 11.
// STRUCTURE
//  Package lsu_pkg: SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL codes, state encoding (IDLE, SPLIT),
//   LANE_W=8, NUM_LANES=4.
//  Sub-module lsu_align (combinational): off, size, wdata -> wide_mask, wide_data;
//   {hi,lo}, off, size, uns -> extended rdata. The FSM and registers stay in lsu_mem_ctrl.
// TESTING
//  1 store byte 0xA5 @0x07 -> one cycle: mem_waddr=0x04, wmask=1000, wdata=0xA5000000; rsp next cycle.
//  2 store word 0x11223344 @0x02 -> cycle0: waddr=0x00, wmask=1100, wdata=0x33440000;
//    cycle1: waddr=0x04, wmask=0011, wdata=0x00001122; req_ready=0 in cycle1.
//  3 mem[0]=0x80FF0000, mem[1]=0x00000001, load half signed @0x03 -> rsp_rdata=0x00000180
//    after 2 cycles; same load unsigned @0x02 -> 0x000080FF after 1 cycle.
//  4 load byte signed @0x01 with mem[0]=0x00008000 -> 0xFFFFFF80; with req_uns=1 -> 0x00000080.
//  5 size=11 store @0x00 -> mem_we stays 0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  6 DEPTH=32, store half @0x7F -> byte 3 of word 31, then byte 0 of word 0 (wrap).
//    Repeat with rst=1 in the SPLIT cycle -> word 0 unchanged, no rsp_valid, req_ready=1 after reset.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer: access-size codes,
// FSM state encoding and byte-lane geometry.
package lsu_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Number of bytes touched by an access; 0 for the illegal code.
  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store mask/data shift across a two-word window, and
// load data extraction with sign/zero extension from a {hi,lo} word pair.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_hi,
  input  logic [31:0] rd_lo,
  output logic [6:0]  wide_mask,
  output logic [55:0] wide_data,
  output logic [31:0] ext_rdata
);

  logic [3:0]  base_mask;
  logic [31:0] shifted;

  // NOTE: every always_comb output gets a value on every path (default arms
  // here, defaults-first in the controller) so no latch can be inferred.
  always_comb begin
    case (size)
      SZ_BYTE: base_mask = 4'b0001;
      SZ_HALF: base_mask = 4'b0011;
      SZ_WORD: base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase

    wide_mask = {3'b000, base_mask} << off;
    wide_data = {24'd0, wdata} << {off, 3'b000};
    shifted   = 32'({rd_hi, rd_lo} >> {off, 3'b000});

    case (size)
      SZ_BYTE: ext_rdata = {{24{~uns & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ext_rdata = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: ext_rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer in front of a word-organised data memory; misaligned
// accesses that straddle a word boundary are split into two word accesses.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int MEM_AW = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_uns,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [MEM_AW-1:0] mem_waddr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_we,
  output logic [3:0]        mem_wmask
);

  localparam int WORD_AW = MEM_AW - 2;

  state_e             state_q, state_d;
  logic [WORD_AW-1:0] word_q, word_d;
  logic [1:0]         off_q, off_d;
  size_e              size_q, size_d;
  logic               uns_q, uns_d;
  logic               we_q, we_d;
  logic [2:0]         hi_mask_q, hi_mask_d;
  logic [23:0]        hi_data_q, hi_data_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]    rsp_rdata_q, rsp_rdata_d;

  size_e              req_sz;
  logic               split;
  logic [1:0]         al_off;
  size_e              al_size;
  logic               al_uns;
  logic [XLEN-1:0]    al_lo;
  logic [6:0]         wide_mask;
  logic [55:0]        wide_data;
  logic [XLEN-1:0]    ext_rdata;
  logic [MEM_AW-1:0]  mem_addr;
  logic               we_raw;

  assign req_sz = size_e'(req_size);
  assign split  = ({1'b0, req_addr[1:0]} + size_bytes(req_sz)) > 3'd4;

  lsu_align u_align (
    .off       (al_off),
    .size      (al_size),
    .uns       (al_uns),
    .wdata     (req_wdata),
    .rd_hi     (mem_rdata),
    .rd_lo     (al_lo),
    .wide_mask (wide_mask),
    .wide_data (wide_data),
    .ext_rdata (ext_rdata)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    hi_mask_d   = hi_mask_q;
    hi_data_d   = hi_data_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    req_ready   = 1'b0;
    mem_addr    = '0;
    we_raw      = 1'b0;
    mem_wmask   = 4'b0000;
    mem_wdata   = '0;
    al_off      = req_addr[1:0];
    al_size     = req_sz;
    al_uns      = req_uns;
    al_lo       = mem_rdata;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        mem_addr  = {req_addr[MEM_AW-1:2], 2'b00};
        if (req_valid) begin
          if (req_sz == SZ_ILL) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            we_raw    = req_we;
            mem_wmask = wide_mask[3:0];
            mem_wdata = wide_data[31:0];
            if (split) begin
              // Word index arithmetic wraps mod DEPTH, so the top word continues at word 0.
              word_d    = req_addr[MEM_AW-1:2] + WORD_AW'(1);
              off_d     = req_addr[1:0];
              size_d    = req_sz;
              uns_d     = req_uns;
              we_d      = req_we;
              hi_mask_d = wide_mask[6:4];
              hi_data_d = wide_data[55:32];
              lo_d      = mem_rdata;
              state_d   = ST_SPLIT;
            end else begin
              rsp_valid_d = 1'b1;
              rsp_rdata_d = req_we ? '0 : ext_rdata;
            end
          end
        end
      end
      ST_SPLIT: begin
        mem_addr    = {word_q, 2'b00};
        al_off      = off_q;
        al_size     = size_q;
        al_uns      = uns_q;
        al_lo       = lo_q;
        we_raw      = we_q;
        mem_wmask   = {1'b0, hi_mask_q};
        mem_wdata   = {8'd0, hi_data_q};
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? '0 : ext_rdata;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_raddr = mem_addr;
  assign mem_waddr = mem_addr;
  // Reset also suppresses a pending second-half write of an aborted split.
  assign mem_we    = we_raw & ~rst;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      hi_mask_q   <= 3'b000;
      hi_data_q   <= '0;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      hi_mask_q   <= hi_mask_d;
      hi_data_q   <= hi_data_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
